// File: rtl/sha256d_nonce_scanner.sv
// SHA256d nonce scanner: sweeps a nonce range through one streaming SHA-256 core
// and reports the first nonce whose double hash meets the compact target.

module sha256_stream #(
    parameter bit MODE = 1'b1
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         s_tvalid_i,
    output logic         s_tready_o,
    input  logic [511:0] s_tdata_i,
    input  logic         s_tlast_i,
    output logic         digest_valid_o,
    output logic [255:0] digest_o
);
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic         busy, last_q;
    logic [5:0]   rnd;
    logic [511:0] w;
    logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, w_nx;
    logic [255:0] hs, hs_sum;

    assign s_tready_o = ~busy;

    always_comb begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[rnd] + w[511:480];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        w_nx = (rotr(w[63:32], 17) ^ rotr(w[63:32], 19) ^ (w[63:32] >> 10)) + w[223:192]
             + (rotr(w[479:448], 7) ^ rotr(w[479:448], 18) ^ (w[479:448] >> 3)) + w[511:480];
        hs_sum = {hs[255:224] + t1 + t2, hs[223:192] + a, hs[191:160] + b, hs[159:128] + c,
                  hs[127:96] + d + t1, hs[95:64] + e, hs[63:32] + f, hs[31:0] + g};
    end

    // One round per cycle; the chaining value returns to IV after the last block of a message.
    always_ff @(posedge clock) begin
        if (rst) begin
            busy           <= 1'b0;
            digest_valid_o <= 1'b0;
            hs             <= IV;
        end else begin
            digest_valid_o <= 1'b0;
            if (!busy && s_tvalid_i) begin
                busy                     <= 1'b1;
                rnd                      <= 6'd0;
                w                        <= s_tdata_i;
                {a, b, c, d, e, f, g, h} <= hs;
                last_q                   <= s_tlast_i | ~MODE;
            end else if (busy) begin
                {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
                w                        <= {w[479:0], w_nx};
                rnd                      <= rnd + 6'd1;
                if (rnd == 6'd63) begin
                    busy <= 1'b0;
                    if (last_q) begin
                        digest_o       <= hs_sum;
                        digest_valid_o <= 1'b1;
                        hs             <= IV;
                    end else begin
                        hs <= hs_sum;
                    end
                end
            end
        end
    end
endmodule

module sha256d_nonce_scanner #(
    parameter int unsigned NONCE_STEP   = 1,
    parameter int unsigned LANE_OFFSET  = 0,
    parameter bit          STOP_ON_FIND = 1'b1
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [31:0]  version_i,
    input  logic [255:0] prev_i,
    input  logic [255:0] root_i,
    input  logic [31:0]  time_i,
    input  logic [31:0]  bits_i,
    input  logic [31:0]  nonce_first_i,
    input  logic [31:0]  nonce_last_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         found_o,
    output logic [31:0]  nonce_o,
    output logic [255:0] hash_o,
    output logic [31:0]  hashes_o
);
    localparam logic [31:0] STEP = 32'(NONCE_STEP);
    localparam logic [31:0] OFFS = 32'(LANE_OFFSET);

    typedef enum logic [3:0] {S_IDLE, S_RANGE, S_B1, S_B2, S_W1, S_B3, S_W2, S_CHK, S_NEXT, S_FIN} state_t;
    state_t state, state_nx;

    function automatic logic [31:0] le32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] brev256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255 - 8*i -: 8];
        return r;
    endfunction

    function automatic logic [255:0] expand_target(input logic [31:0] b);
        logic [255:0] m;
        int unsigned  e;
        m = {232'd0, b[23:0]};
        e = 32'(b[31:24]);
        if (b[23])        return '0;
        else if (e <= 3)  return m >> (8 * (3 - e));
        else if (e <= 32) return m << (8 * (e - 3));
        else              return '1;
    endfunction

    logic [31:0]  version_q, time_q, bits_q, first_q, last_q, n_q;
    logic [255:0] prev_q, root_q, target_q, dig1_q, dig2_q, hash_rev, dig;
    logic         stop_q, new_find, range_end, s_tvalid, s_tready, s_tlast, dig_valid;
    logic [511:0] s_tdata;

    sha256_stream #(.MODE(1'b1)) u_core (
        .clock(clock), .rst(rst), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
        .s_tlast_i(s_tlast), .digest_valid_o(dig_valid), .digest_o(dig)
    );

    assign hash_rev  = brev256(dig2_q);
    assign new_find  = (hash_rev <= target_q) && !found_o;
    assign range_end = (last_q - n_q) < STEP;

    always_ff @(posedge clock) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_i) state_nx = S_RANGE;
            S_RANGE: state_nx = ((last_q - first_q) < OFFS) ? S_FIN : S_B1;
            S_B1:    if (s_tready) state_nx = S_B2;
            S_B2:    if (s_tready) state_nx = S_W1;
            S_W1:    if (dig_valid) state_nx = S_B3;
            S_B3:    if (s_tready) state_nx = S_W2;
            S_W2:    if (dig_valid) state_nx = S_CHK;
            S_CHK:   state_nx = ((new_find && STOP_ON_FIND) || stop_q || range_end) ? S_FIN : S_NEXT;
            S_NEXT:  state_nx = S_B1;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state != S_IDLE) && (state != S_FIN);
        done_o   = (state == S_FIN);
        s_tvalid = (state == S_B1) || (state == S_B2) || (state == S_B3);
        s_tlast  = (state != S_B1);
        case (state)
            S_B1:    s_tdata = {le32(version_q), prev_q, root_q[255:32]};
            S_B3:    s_tdata = {dig1_q, 8'h80, 184'd0, 64'h100};
            default: s_tdata = {root_q[31:0], le32(time_q), le32(bits_q), le32(n_q), 8'h80, 312'd0, 64'h280};
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            found_o  <= 1'b0;
            nonce_o  <= '0;
            hash_o   <= '0;
            hashes_o <= '0;
            stop_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    {version_q, prev_q, root_q, time_q, bits_q} <= {version_i, prev_i, root_i, time_i, bits_i};
                    first_q  <= nonce_first_i;
                    last_q   <= nonce_last_i;
                    found_o  <= 1'b0;
                    nonce_o  <= '0;
                    hash_o   <= '0;
                    hashes_o <= '0;
                    stop_q   <= 1'b0;
                end
                S_RANGE: begin
                    n_q      <= first_q + OFFS;
                    target_q <= expand_target(bits_q);
                end
                S_W1: if (dig_valid) dig1_q <= dig;
                S_W2: if (dig_valid) begin
                    dig2_q   <= dig;
                    hashes_o <= hashes_o + 32'd1;
                end
                S_CHK: begin
                    if (new_find) begin
                        found_o <= 1'b1;
                        nonce_o <= n_q;
                        hash_o  <= hash_rev;
                    end
                    if (state_nx == S_NEXT) n_q <= n_q + STEP;
                end
                default: ;
            endcase
            if (busy_o && stop_i) stop_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sha256d_nonce_scanner.sv
// Bench for sha256d_nonce_scanner: spec vectors, randomized scans against a byte-level
// SHA256d model, plus stop and mid-scan reset sequences.

module tb_sha256d_nonce_scanner;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV [0:7] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] GEN_ROOT = 256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a;
    localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

    logic         clock, rst, stop_s;
    logic         start_s [3];
    logic [31:0]  hv_version, hv_time, hv_bits, hv_first, hv_last;
    logic [255:0] hv_prev, hv_root;
    logic         busy_w [3];
    logic         done_w [3];
    logic         found_w [3];
    logic [31:0]  nonce_w [3];
    logic [255:0] hash_w [3];
    logic [31:0]  hashes_w [3];
    int n_pass, n_tot;

    sha256d_nonce_scanner u_a (
        .clock(clock), .rst(rst), .start_i(start_s[0]), .stop_i(stop_s), .version_i(hv_version), .prev_i(hv_prev),
        .root_i(hv_root), .time_i(hv_time), .bits_i(hv_bits), .nonce_first_i(hv_first), .nonce_last_i(hv_last),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .found_o(found_w[0]), .nonce_o(nonce_w[0]), .hash_o(hash_w[0]),
        .hashes_o(hashes_w[0]));
    sha256d_nonce_scanner #(.STOP_ON_FIND(1'b0)) u_b (
        .clock(clock), .rst(rst), .start_i(start_s[1]), .stop_i(stop_s), .version_i(hv_version), .prev_i(hv_prev),
        .root_i(hv_root), .time_i(hv_time), .bits_i(hv_bits), .nonce_first_i(hv_first), .nonce_last_i(hv_last),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .found_o(found_w[1]), .nonce_o(nonce_w[1]), .hash_o(hash_w[1]),
        .hashes_o(hashes_w[1]));
    sha256d_nonce_scanner #(.NONCE_STEP(4), .LANE_OFFSET(2)) u_c (
        .clock(clock), .rst(rst), .start_i(start_s[2]), .stop_i(stop_s), .version_i(hv_version), .prev_i(hv_prev),
        .root_i(hv_root), .time_i(hv_time), .bits_i(hv_bits), .nonce_first_i(hv_first), .nonce_last_i(hv_last),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .found_o(found_w[2]), .nonce_o(nonce_w[2]), .hash_o(hash_w[2]),
        .hashes_o(hashes_w[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain SHA-256 over an arbitrary byte message.
    function automatic logic [255:0] sha256_msg(input logic [7:0] msg [$]);
        logic [7:0]  m [$];
        logic [31:0] hs [8];
        logic [31:0] v [8];
        logic [31:0] w [64];
        logic [31:0] t1, t2;
        logic [63:0] bl;
        m = msg;
        bl = 64'(msg.size()) * 64'd8;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(bl[8*i +: 8]);
        for (int i = 0; i < 8; i++) hs[i] = IV[i];
        for (int b = 0; b < m.size() / 64; b++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {m[64*b+4*t], m[64*b+4*t+1], m[64*b+4*t+2], m[64*b+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            for (int i = 0; i < 8; i++) v[i] = hs[i];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
                t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hs[i] = hs[i] + v[i];
        end
        return {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
    endfunction

    function automatic logic [255:0] model_hash(input logic [31:0] n);
        logic [7:0]   q [$];
        logic [255:0] d1, d2, hr;
        for (int i = 0; i < 4; i++) q.push_back(hv_version[8*i +: 8]);
        for (int i = 31; i >= 0; i--) q.push_back(hv_prev[8*i +: 8]);
        for (int i = 31; i >= 0; i--) q.push_back(hv_root[8*i +: 8]);
        for (int i = 0; i < 4; i++) q.push_back(hv_time[8*i +: 8]);
        for (int i = 0; i < 4; i++) q.push_back(hv_bits[8*i +: 8]);
        for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
        d1 = sha256_msg(q);
        q.delete();
        for (int i = 31; i >= 0; i--) q.push_back(d1[8*i +: 8]);
        d2 = sha256_msg(q);
        for (int i = 0; i < 32; i++) hr[8*i +: 8] = d2[255 - 8*i -: 8];
        return hr;
    endfunction

    function automatic logic [255:0] model_target(input logic [31:0] b);
        logic [255:0] t;
        int e;
        e = int'(b[31:24]);
        t = 256'(b[22:0]);
        if (b[23]) return '0;
        if (e > 32) return '1;
        for (int i = 3; i < e; i++) t = t * 256;
        for (int i = e; i < 3; i++) t = t / 256;
        return t;
    endfunction

    function automatic void model_scan(input int k, output bit f, output logic [31:0] fn,
                                       output logic [255:0] fh, output logic [31:0] nh);
        logic [31:0]  step, off, n;
        logic [255:0] t, h;
        bit sof;
        step = (k == 2) ? 32'd4 : 32'd1;
        off  = (k == 2) ? 32'd2 : 32'd0;
        sof  = (k != 1);
        f = 1'b0; fn = '0; fh = '0; nh = '0;
        t = model_target(hv_bits);
        if (32'(hv_last - hv_first) < off) return;
        n = hv_first + off;
        while (nh < 32'd100000) begin
            h = model_hash(n);
            nh = nh + 1;
            if (h <= t && !f) begin
                f = 1'b1; fn = n; fh = h;
                if (sof) break;
            end
            if (32'(hv_last - n) < step) break;
            n = n + step;
        end
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_done(input int k, output int ndone);
        int cyc;
        ndone = 0;
        cyc = 0;
        while (ndone == 0 && cyc < 8000) begin
            @(negedge clock);
            cyc++;
            if (done_w[k]) ndone++;
        end
        repeat (20) begin
            @(negedge clock);
            if (done_w[k]) ndone++;
        end
    endtask

    task automatic run_scan(input int k, output int ndone);
        @(negedge clock);
        start_s[k] = 1'b1;
        @(negedge clock);
        start_s[k] = 1'b0;
        check("busy_after_start", 256'(busy_w[k]), 256'(1));
        wait_done(k, ndone);
    endtask

    task automatic set_genesis();
        hv_version = 32'd1; hv_prev = '0; hv_root = GEN_ROOT;
        hv_time = 32'h495FAB29; hv_bits = 32'h1D00FFFF;
    endtask

    typedef struct {
        int          k;
        logic [31:0] first;
        logic [31:0] last;
        logic [31:0] bits;
        bit          found;
        logic [31:0] nonce;
        logic [31:0] hashes;
        int          hsrc;
    } vec_t;

    vec_t tab [9];
    int nd, cyc, k, len;
    bit mf;
    logic [31:0]  mn, mh;
    logic [255:0] mhash;
    logic [31:0]  bits_pick [6];

    initial begin
        tab[0] = '{0, 32'h7C2BAC1D, 32'h7C2BAC1D, 32'h1D00FFFF, 1'b1, 32'h7C2BAC1D, 32'd1, 1};
        tab[1] = '{0, 32'h7C2BAC1A, 32'h7C2BAC30, 32'h1D00FFFF, 1'b1, 32'h7C2BAC1D, 32'd4, 1};
        tab[2] = '{1, 32'h7C2BAC1A, 32'h7C2BAC30, 32'h1D00FFFF, 1'b1, 32'h7C2BAC1D, 32'd23, 1};
        tab[3] = '{0, 32'hFFFFFFFE, 32'h00000001, 32'h1D00FFFF, 1'b0, 32'h0, 32'd4, 0};
        tab[4] = '{2, 32'h00000000, 32'h00000009, 32'h1D00FFFF, 1'b0, 32'h0, 32'd2, 0};
        tab[5] = '{2, 32'h00000000, 32'h00000001, 32'h1D00FFFF, 1'b0, 32'h0, 32'd0, 0};
        tab[6] = '{0, 32'h00000000, 32'h00000003, 32'h2100FFFF, 1'b1, 32'h0, 32'd1, 2};
        tab[7] = '{0, 32'h00000000, 32'h00000003, 32'h1D80FFFF, 1'b0, 32'h0, 32'd4, 0};
        tab[8] = '{2, 32'h00000000, 32'h00000009, 32'h2100FFFF, 1'b1, 32'h2, 32'd1, 2};
        bits_pick = '{32'h2100FFFF, 32'h207FFFFF, 32'h207FFFFF, 32'h1D00FFFF, 32'h1D80FFFF, 32'h03123456};
        n_pass = 0; n_tot = 0;
        rst = 1'b1; stop_s = 1'b0;
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        set_genesis();
        hv_first = '0; hv_last = '0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        check("reset_busy", 256'(busy_w[0]), 256'(0));
        check("reset_done", 256'(done_w[0]), 256'(0));
        check("reset_found", 256'(found_w[0]), 256'(0));
        check("reset_nonce", 256'(nonce_w[0]), 256'(0));
        check("reset_hash", hash_w[0], 256'(0));
        check("reset_hashes", 256'(hashes_w[0]), 256'(0));

        for (int i = 0; i < 9; i++) begin
            set_genesis();
            hv_bits = tab[i].bits; hv_first = tab[i].first; hv_last = tab[i].last;
            run_scan(tab[i].k, nd);
            k = tab[i].k;
            check($sformatf("vec%0d_done_pulses", i), 256'(nd), 256'(1));
            check($sformatf("vec%0d_found", i), 256'(found_w[k]), 256'(tab[i].found));
            check($sformatf("vec%0d_nonce", i), 256'(nonce_w[k]), 256'(tab[i].nonce));
            check($sformatf("vec%0d_hashes", i), 256'(hashes_w[k]), 256'(tab[i].hashes));
            if (tab[i].hsrc == 1) check($sformatf("vec%0d_hash", i), hash_w[k], GEN_HASH);
            else if (tab[i].hsrc == 2) check($sformatf("vec%0d_hash", i), hash_w[k], model_hash(tab[i].nonce));
            else check($sformatf("vec%0d_hash", i), hash_w[k], 256'(0));
        end

        for (int r = 0; r < 10; r++) begin
            k = int'($urandom_range(0, 2));
            hv_version = $urandom; hv_time = $urandom;
            hv_prev = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            hv_root = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            hv_bits = bits_pick[$urandom_range(0, 5)];
            len = (k == 2) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 4));
            hv_first = $urandom;
            hv_last = hv_first + 32'(len);
            model_scan(k, mf, mn, mhash, mh);
            run_scan(k, nd);
            check($sformatf("rnd%0d_done_pulses", r), 256'(nd), 256'(1));
            check($sformatf("rnd%0d_found", r), 256'(found_w[k]), 256'(mf));
            check($sformatf("rnd%0d_nonce", r), 256'(nonce_w[k]), 256'(mn));
            check($sformatf("rnd%0d_hash", r), hash_w[k], mhash);
            check($sformatf("rnd%0d_hashes", r), 256'(hashes_w[k]), 256'(mh));
        end

        // stop request while the second hash is in flight
        set_genesis();
        hv_first = 32'd0; hv_last = 32'd99;
        @(negedge clock); start_s[0] = 1'b1;
        @(negedge clock); start_s[0] = 1'b0;
        cyc = 0;
        while (hashes_w[0] != 32'd1 && cyc < 2000) begin @(negedge clock); cyc++; end
        check("stop_first_hash_seen", 256'(hashes_w[0]), 256'(1));
        repeat (40) @(negedge clock);
        stop_s = 1'b1;
        @(negedge clock);
        stop_s = 1'b0;
        wait_done(0, nd);
        check("stop_done_pulses", 256'(nd), 256'(1));
        check("stop_hashes", 256'(hashes_w[0]), 256'(2));
        check("stop_busy_after", 256'(busy_w[0]), 256'(0));

        // reset in the middle of a scan, with another instance holding a find
        hv_first = 32'd0; hv_last = 32'd0; hv_bits = 32'h2100FFFF;
        run_scan(1, nd);
        check("pre_rst_found_b", 256'(found_w[1]), 256'(1));
        set_genesis();
        hv_first = 32'h7C2BAC1D; hv_last = 32'h7C2BAC1D;
        @(negedge clock); start_s[0] = 1'b1;
        @(negedge clock); start_s[0] = 1'b0;
        repeat (140) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        nd = 0;
        repeat (300) begin @(negedge clock); if (done_w[0]) nd++; end
        check("rst_no_done", 256'(nd), 256'(0));
        check("rst_busy", 256'(busy_w[0]), 256'(0));
        check("rst_found", 256'(found_w[0]), 256'(0));
        check("rst_hashes", 256'(hashes_w[0]), 256'(0));
        check("rst_hash", hash_w[0], 256'(0));
        check("rst_found_b", 256'(found_w[1]), 256'(0));
        check("rst_nonce_b", 256'(nonce_w[1]), 256'(0));
        run_scan(0, nd);
        check("fresh_done_pulses", 256'(nd), 256'(1));
        check("fresh_found", 256'(found_w[0]), 256'(1));
        check("fresh_nonce", 256'(nonce_w[0]), 256'(32'h7C2BAC1D));
        check("fresh_hash", hash_w[0], GEN_HASH);
        check("fresh_hashes", 256'(hashes_w[0]), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
